// File: rtl/wam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wam_pkg
// Brief    : Shared FSM state encoding and BCD constants for the score keeper.
// Revision : 1.0
// ============================================================================
package wam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] BCD_MAX  = 8'h99;
    localparam logic [7:0] BCD_ZERO = 8'h00;

endpackage
`default_nettype wire

// File: rtl/wam_bcd2.sv
`default_nettype none
// ============================================================================
// Module   : wam_bcd2
// Brief    : Combinational saturating two-digit BCD increment/decrement.
// Revision : 1.0
// ============================================================================
module wam_bcd2
    import wam_pkg::*;
(
    input  logic [7:0] cur,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc && !dec) begin
            if (cur != BCD_MAX) begin
                if (cur[3:0] < 4'd9) begin
                    nxt[3:0] = cur[3:0] + 4'd1;
                end else begin
                    nxt[3:0] = 4'd0;
                    nxt[7:4] = cur[7:4] + 4'd1;
                end
            end
        end else if (dec && !inc) begin
            if (cur != BCD_ZERO) begin
                if (cur[3:0] > 4'd0) begin
                    nxt[3:0] = cur[3:0] - 4'd1;
                end else begin
                    nxt[3:0] = 4'd9;
                    nxt[7:4] = cur[7:4] - 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wam_scr.sv
`default_nettype none
// ============================================================================
// Module   : wam_scr
// Brief    : Whac-A-Mole score keeper, game phase FSM and display scan toggle.
// Revision : 1.0
// ============================================================================
module wam_scr
    import wam_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic       game_over,
    output logic [7:0] score,
    output logic       sbit,
    output logic       playing,
    output logic       maxed
);

    localparam int                CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(SCAN_DIV - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_hit_d;
    logic               r_miss_d;
    logic [7:0]         r_score;
    logic [7:0]         w_score_nxt;
    logic [7:0]         w_bcd_nxt;
    logic [CNT_W-1:0]   r_scan_cnt;
    logic               r_sbit;
    logic               w_inc;
    logic               w_dec;

    // Edges only count during play; start/game_over override the result below.
    assign w_inc = (r_state == PLAY) && hit  && !r_hit_d;
    assign w_dec = (r_state == PLAY) && miss && !r_miss_d;

    wam_bcd2 u_bcd2 (
        .cur (r_score),
        .inc (w_inc),
        .dec (w_dec),
        .nxt (w_bcd_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        if (start) begin
            w_state_nxt = PLAY;
            w_score_nxt = BCD_ZERO;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = IDLE;
                PLAY: begin
                    if (game_over) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_score_nxt = w_bcd_nxt;
                    end
                end
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_score  <= BCD_ZERO;
            r_hit_d  <= 1'b0;
            r_miss_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_score  <= w_score_nxt;
            r_hit_d  <= hit;
            r_miss_d <= miss;
        end
    end

    // Free-running scan divider; sbit flips on each wrap for a 50% duty toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_sbit     <= 1'b0;
        end else if (r_scan_cnt == c_cnt_last) begin
            r_scan_cnt <= '0;
            r_sbit     <= ~r_sbit;
        end else begin
            r_scan_cnt <= r_scan_cnt + CNT_W'(1);
        end
    end

    assign score   = r_score;
    assign sbit    = r_sbit;
    assign playing = (r_state == PLAY);
    assign maxed   = (r_score == BCD_MAX);

endmodule
`default_nettype wire

// File: tb/tb_wam_scr.sv
`default_nettype none
// ============================================================================
// Module   : tb_wam_scr
// Brief    : Self-checking bench for wam_scr against an integer score model.
// Revision : 1.0
// ============================================================================
module tb_wam_scr;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       hit;
    logic       miss;
    logic       game_over;
    logic [7:0] score;
    logic       sbit;
    logic       playing;
    logic       maxed;

    int checks;
    int errors;

    // Model: phase 0 idle / 1 play / 2 done, score as a plain integer 0..99.
    int   m_phase;
    int   m_score;
    int   m_edges;
    logic m_hp;
    logic m_mp;

    wam_scr #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hit       (hit),
        .miss      (miss),
        .game_over (game_over),
        .score     (score),
        .sbit      (sbit),
        .playing   (playing),
        .maxed     (maxed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int s);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(s / 10);
        o = 4'(s % 10);
        return {t, o};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_score <= 0;
            m_edges <= 0;
            m_hp    <= 1'b0;
            m_mp    <= 1'b0;
        end else begin
            m_edges <= m_edges + 1;
            m_hp    <= hit;
            m_mp    <= miss;
            if (start) begin
                m_phase <= 1;
                m_score <= 0;
            end else if (m_phase == 1) begin
                if (game_over)
                    m_phase <= 2;
                else if ((hit && !m_hp) && !(miss && !m_mp) && m_score < 99)
                    m_score <= m_score + 1;
                else if ((miss && !m_mp) && !(hit && !m_hp) && m_score > 0)
                    m_score <= m_score - 1;
            end
        end
    end

    // Continuous comparison against the model, mid-cycle.
    always @(negedge clk) begin
        chk("cmp_score",   score,          to_bcd(m_score));
        chk("cmp_sbit",    {7'd0, sbit},   {7'd0, 1'(((m_edges / SCAN_DIV) % 2) == 1)});
        chk("cmp_playing", {7'd0, playing}, {7'd0, 1'(m_phase == 1)});
        chk("cmp_maxed",   {7'd0, maxed},  {7'd0, 1'(m_score == 99)});
    end

    // Apply inputs, let one rising edge sample them, return 2 time units later.
    task automatic drive(input logic h, input logic m, input logic s, input logic g);
        hit = h; miss = m; start = s; game_over = g;
        @(posedge clk);
        #2;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0);
            drive(0, 0, 0, 0);
        end
    endtask

    task automatic misses(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, 0, 0);
            drive(0, 0, 0, 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        hit = 0; miss = 0; start = 0; game_over = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_score", score, 8'h00);
        chk("rst_sbit",  {7'd0, sbit}, 8'h00);
        rst_n = 1'b1;

        // Idle: sbit first toggles on the 4th edge after release.
        for (int k = 1; k <= 20; k++) begin
            drive(0, 0, 0, 0);
            if (k == 3)  chk("sbit_e3",  {7'd0, sbit}, 8'h00);
            if (k == 4)  chk("sbit_e4",  {7'd0, sbit}, 8'h01);
            if (k == 7)  chk("sbit_e7",  {7'd0, sbit}, 8'h01);
            if (k == 8)  chk("sbit_e8",  {7'd0, sbit}, 8'h00);
        end
        chk("idle_score",   score, 8'h00);
        chk("idle_playing", {7'd0, playing}, 8'h00);

        // Hits in IDLE are ignored.
        hits(2);
        chk("idle_hit", score, 8'h00);

        // Carry through 09 -> 10, one-edge latency.
        drive(0, 0, 1, 0);
        chk("start_play", {7'd0, playing}, 8'h01);
        hits(9);
        chk("nine", score, 8'h09);
        drive(1, 0, 0, 0);
        chk("carry_latency", score, 8'h10);
        drive(0, 0, 0, 0);

        // Upper saturation.
        hits(88);
        chk("at98", score, 8'h98);
        hits(1);
        chk("sat1", score, 8'h99);
        hits(1);
        chk("sat2", score, 8'h99);
        hits(1);
        chk("sat3", score, 8'h99);
        chk("maxed", {7'd0, maxed}, 8'h01);

        // Borrow and lower saturation.
        drive(0, 0, 1, 0);
        chk("restart", score, 8'h00);
        hits(10);
        misses(1);
        chk("borrow", score, 8'h09);
        misses(9);
        chk("zero", score, 8'h00);
        misses(1);
        chk("low_sat", score, 8'h00);
        for (int i = 0; i < 50; i++) drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("held_hit", score, 8'h01);

        // Simultaneous events at 42.
        hits(41);
        drive(1, 1, 0, 0);
        chk("both_edges", score, 8'h42);
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 1);
        chk("go_score",   score, 8'h42);
        chk("go_playing", {7'd0, playing}, 8'h00);
        drive(0, 0, 0, 0);
        hits(3);
        chk("done_frozen", score, 8'h42);
        drive(1, 0, 1, 0);
        chk("done_start",   score, 8'h00);
        chk("done_playing", {7'd0, playing}, 8'h01);
        drive(0, 0, 0, 0);

        // Randomized play checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 79) == 0),
                  1'($urandom_range(0, 59) == 0));
        end

        // Async reset mid-play at 57.
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        hits(57);
        chk("at57", score, 8'h57);
        #1 rst_n = 1'b0;
        #1;
        chk("async_score",   score, 8'h00);
        chk("async_sbit",    {7'd0, sbit}, 8'h00);
        chk("async_playing", {7'd0, playing}, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;
        hits(2);
        chk("post_rst_idle", score, 8'h00);
        chk("post_rst_play", {7'd0, playing}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
